// File: rtl/uc_pkg.sv
// uc_pkg: shared definitions for the multicycle RV32I control unit.
// State encoding, opcode constants, aluOp codes, ALU control codes and
// datapath mux select codes used by uc_multiciclo and aludec_mc.
package uc_pkg;

   // FSM state encoding (4 bits, FETCH must be 0 so reset lands there)
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   // Opcodes of the supported subset
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   // aluOp codes fed from the FSM to the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALU control codes (3 significant bits, zero-extended at the output)
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // funct3 values the decoder distinguishes
   localparam logic [2:0] F3_ADDSUB = 3'b000;
   localparam logic [2:0] F3_BNE    = 3'b001;
   localparam logic [2:0] F3_SLT    = 3'b010;
   localparam logic [2:0] F3_OR     = 3'b110;
   localparam logic [2:0] F3_AND    = 3'b111;

   // Result mux
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // ALU A mux
   localparam logic [1:0] A_PC    = 2'b00;
   localparam logic [1:0] A_OLDPC = 2'b01;
   localparam logic [1:0] A_RS1   = 2'b10;

   // ALU B mux
   localparam logic [1:0] B_RS2  = 2'b00;
   localparam logic [1:0] B_IMM  = 2'b01;
   localparam logic [1:0] B_FOUR = 2'b10;

   // Immediate formats
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // Successor of DECODE as a function of the opcode; unknown opcodes trap
   function automatic state_t decode_next(input logic [6:0] op);
      state_t nxt;
      case (op)
         OP_LW, OP_SW: nxt = S_MEMADR;
         OP_RTYPE:     nxt = S_EXECR;
         OP_ITYPE:     nxt = S_EXECI;
         OP_BRANCH:    nxt = S_BRANCH;
         OP_JAL:       nxt = S_JAL;
         default:      nxt = S_TRAP;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/aludec_mc.sv
// aludec_mc: combinational ALU decoder for the multicycle core.
// Maps aluOp plus funct fields onto an ALU control code, zero-extended
// to ALUCTRL_W bits.
module aludec_mc
   import uc_pkg::*;
#(
   parameter int ALUCTRL_W = 3
) (
   input  logic [1:0]           alu_op_i,
   input  logic                 op5_i,
   input  logic [2:0]           f3_i,
   input  logic                 f7_5_i,
   output logic [ALUCTRL_W-1:0] alu_ctrl_o
);

   logic [2:0] code;

   // Select the ALU operation; only R-type (op5=1) with funct7[5] subtracts
   always_comb begin
      code = ALU_ADD;
      case (alu_op_i)
         ALUOP_ADD: code = ALU_ADD;
         ALUOP_SUB: code = ALU_SUB;
         ALUOP_FUNCT: begin
            case (f3_i)
               F3_ADDSUB: code = (op5_i & f7_5_i) ? ALU_SUB : ALU_ADD;
               F3_SLT:    code = ALU_SLT;
               F3_OR:     code = ALU_OR;
               F3_AND:    code = ALU_AND;
               default:   code = ALU_ADD;
            endcase
         end
         default: code = ALU_ADD;
      endcase
   end

   assign alu_ctrl_o = ALUCTRL_W'(code);

endmodule

// File: rtl/uc_multiciclo.sv
// uc_multiciclo: Moore multicycle control unit for the RV32I subset
// (lw, sw, R-type, I-type ALU, beq, jal) with memory-ready stalls,
// a sticky illegal-opcode trap and a retired-instruction counter.
// Optional macro BRANCH_NE_EN: BRANCH also resolves bne (taken = !zero).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instruction at PC, PC+4 -> PC when memory is ready
// DECODE   | read registers, oldPC+imm (branch target) into ALUOut
// MEMADR   | rs1+imm -> ALUOut (load/store address)
// MEMREAD  | read data memory at ALUOut, wait for mem_ready
// MEMWB    | write loaded data to rd
// MEMWRITE | write rs2 to memory at ALUOut, wait for mem_ready
// EXECR    | rs1 op rs2
// EXECI    | rs1 op imm
// ALUWB    | write ALUOut to rd
// BRANCH   | compare rs1/rs2, load target into PC if taken
// JAL      | PC <- target, oldPC+4 into ALUOut for the link write
// TRAP     | illegal opcode, no writes, held until reset
module uc_multiciclo
   import uc_pkg::*;
#(
   parameter int ALUCTRL_W = 3,
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           opcode_s,
   input  logic [2:0]           f3_s,
   input  logic                 f7_5_s,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 pcWrite_s,
   output logic                 adrSrc_s,
   output logic                 memWrite_s,
   output logic                 irWrite_s,
   output logic                 regWrite_s,
   output logic [1:0]           resultSrc_s,
   output logic [1:0]           aluSrcA_s,
   output logic [1:0]           aluSrcB_s,
   output logic [1:0]           inmSrc_s,
   output logic [ALUCTRL_W-1:0] aluCtrl_s,
   output logic                 illegal_s,
   output logic [INSTRET_W-1:0] instret_s
);

   state_t                 state_q, state_d;
   logic                   illegal_q;
   logic [INSTRET_W-1:0]   instret_q;

   logic                   ir_write;
   logic                   pc_update;
   logic                   branch;
   logic                   mem_write;
   logic                   reg_write;
   logic                   adr_src;
   logic [1:0]             result_src;
   logic [1:0]             src_a;
   logic [1:0]             src_b;
   logic [1:0]             alu_op;
   logic                   taken;
   logic                   retire;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:   state_d = decode_next(opcode_s);
         S_MEMADR:   state_d = (opcode_s == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECR,
         S_EXECI,
         S_JAL:      state_d = S_ALUWB;
         S_MEMWB,
         S_ALUWB,
         S_BRANCH:   state_d = S_FETCH;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_FETCH;
      endcase
   end

   // State, sticky trap flag and retired-instruction counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_d == S_TRAP)
            illegal_q <= 1'b1;
         if (retire)
            instret_q <= instret_q + 1'b1;
      end
   end

   // An instruction retires on the cycle its final state hands back to FETCH
   assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) ||
                   (state_q == S_BRANCH) ||
                   ((state_q == S_MEMWRITE) && mem_ready);

   // Moore output decode; FETCH gates its writes on mem_ready so a stall
   // leaves PC and IR untouched
   always_comb begin
      ir_write   = 1'b0;
      pc_update  = 1'b0;
      branch     = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      adr_src    = 1'b0;
      result_src = RES_ALUOUT;
      src_a      = A_PC;
      src_b      = B_RS2;
      alu_op     = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            ir_write   = mem_ready;
            pc_update  = mem_ready;
            src_b      = B_FOUR;
            result_src = RES_ALURESULT;
         end
         S_DECODE: begin
            src_a = A_OLDPC;
            src_b = B_IMM;
         end
         S_MEMADR: begin
            src_a = A_RS1;
            src_b = B_IMM;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECR: begin
            src_a  = A_RS1;
            src_b  = B_RS2;
            alu_op = ALUOP_FUNCT;
         end
         S_EXECI: begin
            src_a  = A_RS1;
            src_b  = B_IMM;
            alu_op = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
         end
         S_BRANCH: begin
            src_a  = A_RS1;
            src_b  = B_RS2;
            alu_op = ALUOP_SUB;
            branch = 1'b1;
         end
         S_JAL: begin
            src_a     = A_OLDPC;
            src_b     = B_FOUR;
            pc_update = 1'b1;
         end
         default: ;
      endcase
   end

   // Branch condition; unsupported funct3 values fall through untaken
   always_comb begin
      taken = 1'b0;
      if (f3_s == F3_ADDSUB)
         taken = zero;
`ifdef BRANCH_NE_EN
      else if (f3_s == F3_BNE)
         taken = ~zero;
`endif
   end

   // Immediate format straight from the opcode
   always_comb begin
      inmSrc_s = IMM_I;
      case (opcode_s)
         OP_SW:     inmSrc_s = IMM_S;
         OP_BRANCH: inmSrc_s = IMM_B;
         OP_JAL:    inmSrc_s = IMM_J;
         default:   inmSrc_s = IMM_I;
      endcase
   end

   aludec_mc #(
      .ALUCTRL_W (ALUCTRL_W)
   ) u_aludec (
      .alu_op_i   (alu_op),
      .op5_i      (opcode_s[5]),
      .f3_i       (f3_s),
      .f7_5_i     (f7_5_s),
      .alu_ctrl_o (aluCtrl_s)
   );

   // Write enables are forced low while reset is held
   assign pcWrite_s   = rst_n & (pc_update | (branch & taken));
   assign irWrite_s   = rst_n & ir_write;
   assign memWrite_s  = rst_n & mem_write;
   assign regWrite_s  = rst_n & reg_write;
   assign adrSrc_s    = adr_src;
   assign resultSrc_s = result_src;
   assign aluSrcA_s   = src_a;
   assign aluSrcB_s   = src_b;
   assign illegal_s   = illegal_q;
   assign instret_s   = instret_q;

endmodule

// File: doc/uc_multiciclo.md
# uc_multiciclo

Multicycle control unit for the RV32I subset core (lw, sw, R-type, I-type ALU, beq, jal). A Moore finite-state machine (FSM) sequences fetch, decode, execute, memory and writeback over several cycles on a shared memory and ALU. It adds a memory-ready handshake for variable-latency memory, an illegal-opcode trap and a retired-instruction counter. It sits between the instruction register and the multicycle datapath, and replaces the single-cycle control unit.

## Interface
- `ALUCTRL_W`, default 3: ALU control width. Codes are zero-extended into this width.
- `INSTRET_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode_s`  in  7  opcode from the instruction register.
- `f3_s`  in  3  funct3.
- `f7_5_s`  in  1  funct7 bit 5.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory access completes this cycle.
- `pcWrite_s`  out  1  PC load enable.
- `adrSrc_s`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memWrite_s`  out  1  memory write enable.
- `irWrite_s`  out  1  instruction register and oldPC load enable.
- `regWrite_s`  out  1  register file write enable.
- `resultSrc_s`  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `aluSrcA_s`  out  2  ALU A mux: 00 = PC, 01 = oldPC, 10 = rs1.
- `aluSrcB_s`  out  2  ALU B mux: 00 = rs2, 01 = imm, 10 = constant 4.
- `inmSrc_s`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `aluCtrl_s`  out  ALUCTRL_W  ALU operation.
- `illegal_s`  out  1  sticky illegal-opcode flag.
- `instret_s`  out  INSTRET_W  count of retired instructions.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- Transitions:
  - FETCH→DECODE when `mem_ready`=1.
  - DECODE→ by opcode:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - 1100011 → BRANCH.
    - 1101111 → JAL.
    - any other opcode → TRAP.
  - MEMADR→MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD→MEMWB when `mem_ready`=1.
  - MEMWRITE→FETCH when `mem_ready`=1.
  - EXECR, EXECI, JAL → ALUWB.
  - MEMWB, ALUWB, BRANCH → FETCH.
  - TRAP is absorbing: it holds until reset.
- Outputs per state. Any signal not listed is 0; the aluOp column feeds the ALU decoder.
  - FETCH: adrSrc 0, irWrite=mem_ready, A 00, B 10, aluOp 00, resultSrc 10, pcUpdate=mem_ready.
  - DECODE: A 01, B 01, aluOp 00 (computes the branch target).
  - MEMADR: A 10, B 01, aluOp 00.
  - MEMREAD: adrSrc 1.
  - MEMWB: resultSrc 01, regWrite 1.
  - MEMWRITE: adrSrc 1, memWrite 1.
  - EXECR: A 10, B 00, aluOp 10.
  - EXECI: A 10, B 01, aluOp 10.
  - ALUWB: resultSrc 00, regWrite 1.
  - BRANCH: A 10, B 00, aluOp 01, resultSrc 00, branch 1.
  - JAL: A 01, B 10, aluOp 00, resultSrc 00, pcUpdate 1.
  - TRAP: all write enables 0, `illegal_s` 1.
- `pcWrite_s` = pcUpdate | (branch & taken).
  - taken = `zero` for f3=000.
- `inmSrc_s` is combinational from the opcode: lw and I-type 00, sw 01, branch 10, jal 11.
- ALU decoder:
  - aluOp 00 → add 000.
  - aluOp 01 → sub 001.
  - aluOp 10 → by f3:
    - f3 000 → sub if opcode_s[5]&f7_5_s, else add.
    - f3 010 → slt 101.
    - f3 110 → or 011.
    - f3 111 → and 010.
    - any other f3 → add.
- `instret_s` increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH. It wraps modulo 2^INSTRET_W.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state=FETCH, `instret_s`=0, `illegal_s`=0.
  - `pcWrite_s`, `irWrite_s`, `memWrite_s` and `regWrite_s` are forced to 0 while reset is asserted.
- Release: the first rising edge after `rst_n`=1 evaluates FETCH normally.
- Reset asserted mid-instruction aborts it with no writes, and `instret_s` returns to 0.
- Outputs are Moore from the state, except:
  - `pcWrite_s` and `irWrite_s`: combinational on `zero` and `mem_ready`.
  - `aluCtrl_s` and `inmSrc_s`: combinational on opcode and funct fields.
- Latency with `mem_ready` held at 1: lw 5, sw 4, R-type 4, I-type 4, branch 3, jal 4 cycles.
- Each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
  - In FETCH, no PC or instruction register update happens while stalled.
  - In MEMWRITE, `memWrite_s` stays high throughout the stall.

## Configuration
- `BRANCH_NE_EN` defined: BRANCH also handles bne (f3=001, taken=!zero).
- Undefined: branches with f3≠000 are never taken; they still retire.

## Structure
- Shared package `uc_pkg`:
  - state enum, 4-bit encoding, FETCH=0.
  - opcode constants.
  - aluOp codes.
  - ALU control codes.
- Sub-module `aludec_mc` (combinational ALU decoder, parametrised by ALUCTRL_W).
- FSM, output decode and counter live in the top module.

## Test plan
- Reset then add (0110011, f3 000, f7_5 0), `mem_ready`=1 → states FETCH, DECODE, EXECR, ALUWB.
  - `regWrite_s`=1 only in cycle 4.
  - `aluCtrl_s`=000 in EXECR.
  - `instret_s`=1 after cycle 4.
- lw with `mem_ready` low for 2 cycles in MEMREAD → 7 cycles total, `regWrite_s` once in MEMWB.
- sw → `memWrite_s`=1 only in MEMWRITE, `adrSrc_s`=1, `inmSrc_s`=01.
- beq with `zero`=1 → `pcWrite_s`=1 in BRANCH; with `zero`=0 → 0. Both take 3 cycles and both retire.
- Opcode 1111111 → TRAP, `illegal_s`=1, `instret_s` frozen.
  - `rst_n` pulsed low mid-TRAP → FETCH, `illegal_s`=0.
- With `BRANCH_NE_EN`: bne with `zero`=0 → `pcWrite_s`=1. Without it → 0.
